// File: rtl/fp32_dense_layer_if.sv
// Port bundle for fp32_dense_layer: start/activation control, weight write port,
// neuron results and status, plus the FSM state for observation.
interface fp32_dense_layer_if #(
    parameter int WIDTH = 5
);
    logic              start;
    logic              activation_function;
    logic [31:0]       data_in1;
    logic [31:0]       data_in2;
    logic [31:0]       data_in3;
    logic [31:0]       data_in4;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_addr;
    logic [31:0]       wr_data;
    logic [31:0]       data_out1;
    logic [31:0]       data_out2;
    logic [31:0]       data_out3;
    logic [31:0]       data_out4;
    logic              busy;
    logic              done;
    logic [2:0]        fsm_state;

    // start is a single-cycle request, honoured only while busy is low; done holds
    // from completion until the next accepted start or reset.
    modport master (
        output start, activation_function, data_in1, data_in2, data_in3, data_in4,
        output wr_en, wr_addr, wr_data,
        input  data_out1, data_out2, data_out3, data_out4, busy, done, fsm_state
    );

    modport slave (
        input  start, activation_function, data_in1, data_in2, data_in3, data_in4,
        input  wr_en, wr_addr, wr_data,
        output data_out1, data_out2, data_out3, data_out4, busy, done, fsm_state
    );
endinterface

// File: rtl/fp32_dense_layer.sv
// Sequential FP32 fully-connected layer: 4 inputs, NUM_OUT neurons, bias and optional
// ReLU, using one shared truncating multiplier and one shared truncating adder.
module fp32_dense_layer #(
    parameter int WIDTH   = 5,
    parameter int NUM_OUT = 4
) (
    input  logic            clk,
    input  logic            rstn,
    fp32_dense_layer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MUL, S_ADD, S_FINISH, S_DONE} state_t;

    state_t             state, next;
    logic [31:0]        mem [2**WIDTH];
    logic [3:0][31:0]   x;
    logic [3:0][31:0]   dout;
    logic [31:0]        acc, prod, rd_data, sum;
    logic [1:0]         neuron, in_idx;
    logic               relu, busy_int, accept, last_neuron;
    logic [2:0]         sel;
    logic [4:0]         addr5;
    logic [WIDTH-1:0]   rd_addr;

    // Truncating multiply; zero/denormal operands and underflow give +0.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]       ma, mb, p;
        logic signed [9:0] e;
        logic [22:0]       m;
        ma = {24'b0, 1'b1, a[22:0]};
        mb = {24'b0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'sd1;
        end else begin
            m = p[45:23];
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0) return 32'h0;
        if (e >= 10'sd255) return {a[31] ^ b[31], 8'hff, 23'h0};
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Truncating add; 27 extra low bits plus a sticky bit keep subtraction exact-then-truncate.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big, sml;
        logic [7:0]        d;
        logic [51:0]       bm, sm, r, nrm;
        logic [5:0]        lead;
        logic signed [9:0] e;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return 32'h0;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        bm = {1'b0, 1'b1, big[22:0], 27'b0};
        sm = {1'b0, 1'b1, sml[22:0], 27'b0};
        sm = (sm >> d) | {51'b0, ((sm >> d) << d) != sm};
        r  = (big[31] == sml[31]) ? bm + sm : bm - sm;
        if (r == 52'd0) return 32'h0;
        lead = 6'd0;
        for (int k = 0; k < 52; k++) begin
            if (r[k]) lead = 6'(k);
        end
        nrm = r << (6'd51 - lead);
        e   = $signed({2'b0, big[30:23]}) + $signed({4'b0, lead}) - 10'sd50;
        if (e <= 10'sd0) return 32'h0;
        if (e >= 10'sd255) return {big[31], 8'hff, 23'h0};
        return {big[31], e[7:0], nrm[50:28]};
    endfunction

    assign busy_int    = (state != S_IDLE) && (state != S_DONE);
    assign accept      = !busy_int && bus.start;
    assign last_neuron = (neuron == 2'(NUM_OUT - 1));
    assign sel         = (state == S_BIAS) ? 3'd4 : {1'b0, in_idx};
    assign addr5       = 5'(neuron) * 5'd5 + 5'(sel);
    assign rd_addr     = WIDTH'(addr5);
    assign rd_data     = mem[rd_addr];
    assign sum         = fp_add(acc, prod);

    // Weight file has no reset; writes are locked out while computing.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy_int) mem[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE, S_DONE: if (bus.start) next = S_BIAS;
            S_BIAS:         next = S_MUL;
            S_MUL:          next = S_ADD;
            S_ADD: begin
                if (in_idx != 2'd3)   next = S_MUL;
                else if (last_neuron) next = S_FINISH;
                else                  next = S_BIAS;
            end
            S_FINISH:       next = S_DONE;
            default:        next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x      <= '0;
            dout   <= '0;
            acc    <= '0;
            prod   <= '0;
            relu   <= 1'b0;
            neuron <= 2'd0;
            in_idx <= 2'd0;
        end else begin
            if (accept) begin
                x      <= {bus.data_in4, bus.data_in3, bus.data_in2, bus.data_in1};
                relu   <= bus.activation_function;
                neuron <= 2'd0;
                in_idx <= 2'd0;
            end
            case (state)
                S_BIAS: acc  <= rd_data;
                S_MUL:  prod <= fp_mul(rd_data, x[in_idx]);
                S_ADD: begin
                    acc    <= sum;
                    in_idx <= in_idx + 2'd1;
                    if (in_idx == 2'd3) begin
                        dout[neuron] <= (relu && sum[31]) ? 32'h0 : sum;
                        neuron       <= neuron + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out1 = dout[0];
    assign bus.data_out2 = dout[1];
    assign bus.data_out3 = dout[2];
    assign bus.data_out4 = dout[3];
    assign bus.busy      = busy_int;
    assign bus.done      = (state == S_DONE);
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_fp32_dense_layer.sv
// Bench for fp32_dense_layer: directed vector table, randomized layers against a
// real-arithmetic truncation model, latency, reset and write-lockout sequences.
module tb_fp32_dense_layer;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fp32_dense_layer_if #(.WIDTH(5)) hid_if();
    fp32_dense_layer_if #(.WIDTH(5)) out_if();

    fp32_dense_layer #(.WIDTH(5), .NUM_OUT(4)) u_hid (.clk(clk), .rstn(rstn), .bus(hid_if.slave));
    fp32_dense_layer #(.WIDTH(5), .NUM_OUT(1)) u_out (.clk(clk), .rstn(rstn), .bus(out_if.slave));

    typedef struct {
        logic [3:0][31:0] w;
        logic [3:0][31:0] b;
        logic [3:0][31:0] x;
        logic             act;
        logic             skip_b0;
        logic [3:0][31:0] e;
    } vec_t;

    vec_t             vecs[5];
    logic [3:0][3:0][31:0] hw;
    logic [3:0][31:0] hb;
    logic [3:0][31:0] ow;
    logic [31:0]      ob;

    // ---------------- reference model (real arithmetic, round toward zero) ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic [63:0] d;
        int          e;
        if (v == 0.0) return 32'h0;
        d = $realtobits(v);
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {d[63], 8'hff, 23'h0};
        if (e <= 0) return 32'h0;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    // Double sum plus its exact error term; step one ulp toward zero when the
    // rounded double sits on an fp32 value but the true sum is slightly smaller.
    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        real ra, rb, s, bb, err;
        logic [31:0] r;
        ra  = f2r(a);
        rb  = f2r(b);
        s   = ra + rb;
        bb  = s - ra;
        err = (ra - (s - bb)) + (rb - bb);
        r   = r2f(s);
        if (r != 32'h0 && err != 0.0 && ((s > 0.0) != (err > 0.0)) && f2r(r) == s) begin
            r = r - 32'd1;
            if (r[30:23] == 8'd0) r = 32'h0;
        end
        return r;
    endfunction

    function automatic logic [31:0] m_neuron(input logic [3:0][31:0] w, input logic [31:0] b,
                                             input logic [3:0][31:0] x, input logic act);
        logic [31:0] acc;
        acc = b;
        for (int i = 0; i < 4; i++) acc = m_add(acc, m_mul(w[i], x[i]));
        if (act && acc[31]) acc = 32'h0;
        return acc;
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    // ---------------- access helpers ----------------
    function automatic logic [31:0] get_out(input int inst, input int k);
        logic [31:0] v;
        if (inst == 0) v = (k == 0) ? hid_if.data_out1 : (k == 1) ? hid_if.data_out2 :
                           (k == 2) ? hid_if.data_out3 : hid_if.data_out4;
        else           v = (k == 0) ? out_if.data_out1 : (k == 1) ? out_if.data_out2 :
                           (k == 2) ? out_if.data_out3 : out_if.data_out4;
        return v;
    endfunction

    function automatic logic get_busy(input int inst);
        return (inst == 0) ? hid_if.busy : out_if.busy;
    endfunction

    function automatic logic get_done(input int inst);
        return (inst == 0) ? hid_if.done : out_if.done;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (called and returning just after a negedge) ----------------
    task automatic set_start(input int inst, input logic s, input logic act);
        if (inst == 0) begin hid_if.start = s; hid_if.activation_function = act; end
        else           begin out_if.start = s; out_if.activation_function = act; end
    endtask

    task automatic set_wr(input int inst, input logic en, input logic [4:0] a, input logic [31:0] d);
        if (inst == 0) begin hid_if.wr_en = en; hid_if.wr_addr = a; hid_if.wr_data = d; end
        else           begin out_if.wr_en = en; out_if.wr_addr = a; out_if.wr_data = d; end
    endtask

    task automatic set_x(input int inst, input logic [3:0][31:0] x);
        if (inst == 0) begin
            hid_if.data_in1 = x[0]; hid_if.data_in2 = x[1]; hid_if.data_in3 = x[2]; hid_if.data_in4 = x[3];
        end else begin
            out_if.data_in1 = x[0]; out_if.data_in2 = x[1]; out_if.data_in3 = x[2]; out_if.data_in4 = x[3];
        end
    endtask

    task automatic wr(input int inst, input logic [4:0] a, input logic [31:0] d);
        set_wr(inst, 1'b1, a, d);
        @(posedge clk);
        @(negedge clk);
        set_wr(inst, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic load_hidden(input int skip);
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++)
                if (n * 5 + i != skip) wr(0, 5'(n * 5 + i), hw[n][i]);
            if (n * 5 + 4 != skip) wr(0, 5'(n * 5 + 4), hb[n]);
        end
    endtask

    task automatic load_output();
        for (int i = 0; i < 4; i++) wr(1, 5'(i), ow[i]);
        wr(1, 5'd4, ob);
    endtask

    task automatic run(input int inst, input logic act, input bit sw, input logic [4:0] sa,
                       input logic [31:0] sd, input bit bw, input string tag);
        int k, busy_cnt, lat;
        lat = (inst == 0) ? 37 : 10;
        set_start(inst, 1'b1, act);
        if (sw) set_wr(inst, 1'b1, sa, sd);
        @(posedge clk);
        @(negedge clk);
        set_start(inst, 1'b0, 1'b0);
        set_wr(inst, 1'b0, 5'd0, 32'h0);
        k = 0;
        busy_cnt = 0;
        while (!get_done(inst) && k < 100) begin
            if (get_busy(inst)) busy_cnt++;
            if (bw && k == 3) set_wr(inst, 1'b1, 5'd15, 32'h42C80000);
            @(posedge clk);
            k++;
            @(negedge clk);
            set_wr(inst, 1'b0, 5'd0, 32'h0);
        end
        check({tag, "_latency"}, 32'(k), 32'(lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
        check({tag, "_busy_low"}, 32'(get_busy(inst)), 32'h0);
    endtask

    task automatic compare_outputs(input int inst, input string tag);
        logic [31:0] e;
        for (int k = 0; k < 4; k++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_queue_empty actual=none required=entry", tag);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_out%0d", tag, k + 1), get_out(inst, k), e);
            end
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int inst = 0; inst < 2; inst++) begin
            for (int k = 0; k < 4; k++)
                check($sformatf("%s_i%0d_out%0d", tag, inst, k + 1), get_out(inst, k), 32'h0);
            check($sformatf("%s_i%0d_busy", tag, inst), 32'(get_busy(inst)), 32'h0);
            check($sformatf("%s_i%0d_done", tag, inst), 32'(get_done(inst)), 32'h0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0][31:0] x1, hexp, hx;
        logic             act;

        set_start(0, 1'b0, 1'b0); set_start(1, 1'b0, 1'b0);
        set_wr(0, 1'b0, 5'd0, 32'h0); set_wr(1, 1'b0, 5'd0, 32'h0);
        set_x(0, '0); set_x(1, '0);

        x1 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        for (int v = 0; v < 5; v++) begin
            vecs[v].w = {4{32'h3F800000}};
            vecs[v].b = '0;
            vecs[v].x = x1;
            vecs[v].act = 1'b0;
            vecs[v].skip_b0 = 1'b0;
            vecs[v].e = {4{32'h41200000}};
        end
        vecs[1].w[0] = 32'h3F000000; vecs[1].b[0] = 32'h3F000000; vecs[1].skip_b0 = 1'b1;
        vecs[1].e[0] = 32'h40B00000;
        vecs[2].w[1] = 32'hBF800000; vecs[2].e[1] = 32'hC1200000;
        vecs[3].w[1] = 32'hBF800000; vecs[3].act = 1'b1; vecs[3].e[1] = 32'h00000000;
        vecs[4].w = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[4].b = {32'h3F800000, 32'h00000000, 32'hC1F00000, 32'hBF800000};
        vecs[4].act = 1'b1;
        vecs[4].e = {32'h41300000, 32'h41200000, 32'h00000000, 32'h41980000};

        // Reset held, then released with no start.
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check_idle_zero("post_reset");

        // Directed vector table.
        for (int v = 0; v < 5; v++) begin
            for (int n = 0; n < 4; n++) begin
                for (int i = 0; i < 4; i++) hw[n][i] = vecs[v].w[n];
                hb[n] = vecs[v].b[n];
            end
            load_hidden(vecs[v].skip_b0 ? 4 : -1);
            set_x(0, vecs[v].x);
            for (int k = 0; k < 4; k++) exp_q.push_back(vecs[v].e[k]);
            run(0, vecs[v].act, vecs[v].skip_b0, 5'd4, vecs[v].b[0], v == 2, $sformatf("vec%0d", v));
            compare_outputs(0, $sformatf("vec%0d", v));
            if (v == 0) begin
                ow = {4{32'h3F800000}};
                ob = 32'h0;
                load_output();
                set_x(1, {hid_if.data_out4, hid_if.data_out3, hid_if.data_out2, hid_if.data_out1});
                exp_q.push_back(32'h42200000);
                for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
                run(1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "outlayer");
                compare_outputs(1, "outlayer");
            end
        end

        // Abort mid-run with reset, then recompute from the retained weights.
        set_start(0, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        check("midrun_busy_before_reset", 32'(hid_if.busy), 32'h1);
        rstn = 1'b0;
        #1;
        check_idle_zero("midrun_reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) exp_q.push_back(vecs[4].e[k]);
        run(0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, "restart");
        compare_outputs(0, "restart");

        // Randomized layers and chained output layer against the model.
        for (int t = 0; t < 8; t++) begin
            for (int n = 0; n < 4; n++) begin
                for (int i = 0; i < 4; i++) hw[n][i] = rnd_f();
                hb[n] = rnd_f();
                hx[n] = rnd_f();
            end
            act = 1'($urandom);
            load_hidden(-1);
            set_x(0, hx);
            for (int n = 0; n < 4; n++) begin
                hexp[n] = m_neuron(hw[n], hb[n], hx, act);
                exp_q.push_back(hexp[n]);
            end
            run(0, act, 1'b0, 5'd0, 32'h0, t[0], $sformatf("rnd%0d", t));
            compare_outputs(0, $sformatf("rnd%0d", t));
            for (int i = 0; i < 4; i++) ow[i] = rnd_f();
            ob = rnd_f();
            load_output();
            set_x(1, {hid_if.data_out4, hid_if.data_out3, hid_if.data_out2, hid_if.data_out1});
            exp_q.push_back(m_neuron(ow, ob, hexp, t[1]));
            for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
            run(1, t[1], 1'b0, 5'd0, 32'h0, 1'b0, $sformatf("rndout%0d", t));
            compare_outputs(1, $sformatf("rndout%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
